// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the synchronous FIFO.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic bit is_pow2(int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DW storage: one synchronous write port, one read port that is
// registered in FIFO_STD mode and combinational in FIFO_FWFT mode.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int         DW    = 8,
    parameter int         DEPTH = 8,
    parameter fifo_mode_e MODE  = FIFO_STD
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset so it maps onto RAM; validity is tracked
    // by the pointers and count in the parent, never by the contents.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    if (MODE == FIFO_FWFT) begin : g_fwft
        assign rdata = mem_q[raddr];
    end else begin : g_std
        // NOTE: non-blocking assignment for every register, so all flops
        // sample pre-edge values regardless of process ordering.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  rdata <= '0;
            else if (re) rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO: pointers, fill count, registered flags and sticky
// overflow/underflow around a fifo_mem storage block.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int         DW     = 8,
    parameter int         DEPTH  = 8,
    parameter fifo_mode_e MODE   = FIFO_STD,
    parameter int         AF_LVL = DEPTH - 2,
    parameter int         AE_LVL = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     w_en,
    input  logic [DW-1:0]            w_data,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     r_en,
    output logic [DW-1:0]            r_data,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("fifo_sync: DEPTH must be a power of two and >= 2");
    end
    if (AF_LVL < 1 || AF_LVL > DEPTH - 1) begin : g_bad_af
        $error("fifo_sync: AF_LVL must be within 1..DEPTH-1");
    end
    if (AE_LVL < 1 || AE_LVL > DEPTH - 1) begin : g_bad_ae
        $error("fifo_sync: AE_LVL must be within 1..DEPTH-1");
    end

    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_nxt;
    logic          full_q, afull_q, empty_q, aempty_q;
    logic          overflow_q, underflow_q;
    logic          w_fire, r_fire;
    logic [DW-1:0] mem_rdata;

    // Fires use the registered flags, so a read never frees space for a
    // same-cycle write when full, nor a write feed a same-cycle read when empty.
    assign w_fire = w_en && !full_q  && !clr;
    assign r_fire = r_en && !empty_q && !clr;

    // NOTE: default assigned first so every path drives count_nxt (no latch).
    always_comb begin
        count_nxt = count_q;
        if (w_fire && !r_fire)      count_nxt = count_q + 1'b1;
        else if (r_fire && !w_fire) count_nxt = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clr) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            // Pointers are exactly AW bits wide, so DEPTH-1 -> 0 wraps for free.
            if (w_fire) wptr_q <= wptr_q + 1'b1;
            if (r_fire) rptr_q <= rptr_q + 1'b1;
            count_q  <= count_nxt;
            full_q   <= (count_nxt == CW'(DEPTH));
            afull_q  <= (count_nxt >= CW'(AF_LVL));
            empty_q  <= (count_nxt == '0);
            aempty_q <= (count_nxt <= CW'(AE_LVL));
            if (w_en && full_q)  overflow_q  <= 1'b1;
            if (r_en && empty_q) underflow_q <= 1'b1;
        end
    end

    fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .MODE  (MODE)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_fire),
        .waddr (wptr_q),
        .wdata (w_data),
        .re    (r_fire),
        .raddr (rptr_q),
        .rdata (mem_rdata)
    );

    // In FWFT the head word is only meaningful while non-empty; masking to
    // zero gives a defined value out of reset.
    if (MODE == FIFO_FWFT) begin : g_rd_fwft
        assign r_data = empty_q ? '0 : mem_rdata;
    end else begin : g_rd_std
        assign r_data = mem_rdata;
    end

    assign count        = count_q;
    assign full         = full_q;
    assign almost_full  = afull_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed and random bench driving a FIFO_STD and a FIFO_FWFT instance with
// identical stimulus; flags and counts must agree, read data per mode.
module tb_fifo_sync;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] w_data = '0;

    logic       s_full, s_af, s_empty, s_ae, s_ov, s_un;
    logic [7:0] s_r_data;
    logic [3:0] s_count;
    logic       f_full, f_af, f_empty, f_ae, f_ov, f_un;
    logic [7:0] f_r_data;
    logic [3:0] f_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    fifo_sync #(.DW(8), .DEPTH(8), .MODE(FIFO_STD), .AF_LVL(6), .AE_LVL(2)) u_std (
        .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .w_data(w_data),
        .full(s_full), .almost_full(s_af), .r_en(r_en), .r_data(s_r_data),
        .empty(s_empty), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ov), .underflow(s_un)
    );

    fifo_sync #(.DW(8), .DEPTH(8), .MODE(FIFO_FWFT), .AF_LVL(6), .AE_LVL(2)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .w_data(w_data),
        .full(f_full), .almost_full(f_af), .r_en(r_en), .r_data(f_r_data),
        .empty(f_empty), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ov), .underflow(f_un)
    );

    // {full, almost_full, empty, almost_empty} for a given fill level.
    function automatic logic [3:0] exp_flags(int c);
        return {c == 8, c >= 6, c == 0, c <= 2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1; w_en = 1'b0; r_en = 1'b0;
        tick();
        clr = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if ({s_full, s_af, s_empty, s_ae, s_ov, s_un} !== 6'b001100) begin
            errors++; $display("FAIL reset_flags_std: got %b exp 001100", {s_full, s_af, s_empty, s_ae, s_ov, s_un});
        end
        checks++;
        if ({f_full, f_af, f_empty, f_ae, f_ov, f_un} !== 6'b001100) begin
            errors++; $display("FAIL reset_flags_fwft: got %b exp 001100", {f_full, f_af, f_empty, f_ae, f_ov, f_un});
        end
        checks++;
        if (s_count !== 4'd0 || s_r_data !== 8'h00 || f_r_data !== 8'h00) begin
            errors++; $display("FAIL reset_count_data: got count %0d std %h fwft %h exp 0 00 00", s_count, s_r_data, f_r_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            w_en = 1'b1; w_data = 8'h10 + 8'(i);
            tick();
            checks++;
            if (s_count !== 4'(i + 1) || f_count !== 4'(i + 1)) begin
                errors++; $display("FAIL fill_count: got %0d/%0d exp %0d", s_count, f_count, i + 1);
            end
            checks++;
            if ({s_full, s_af, s_empty, s_ae} !== exp_flags(i + 1)) begin
                errors++; $display("FAIL fill_flags: got %b exp %b at count %0d", {s_full, s_af, s_empty, s_ae}, exp_flags(i + 1), i + 1);
            end
            checks++;
            if (f_r_data !== 8'h10) begin
                errors++; $display("FAIL fill_fwft_head: got %h exp 10", f_r_data);
            end
        end
        w_data = 8'h99;
        tick();
        w_en = 1'b0;
        checks++;
        if (s_ov !== 1'b1 || f_ov !== 1'b1 || s_count !== 4'd8 || s_full !== 1'b1) begin
            errors++; $display("FAIL fill_overflow: got ov %b/%b count %0d full %b exp 1/1 8 1", s_ov, f_ov, s_count, s_full);
        end
    endtask

    task automatic test_drain_std();
        for (int i = 0; i < 8; i++) begin
            r_en = 1'b1;
            checks++;
            if (f_r_data !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL drain_fwft_head: got %h exp %h", f_r_data, 8'h10 + 8'(i));
            end
            checks++;
            if (s_r_data !== ((i == 0) ? 8'h00 : 8'h0F + 8'(i))) begin
                errors++; $display("FAIL drain_std_before_edge: got %h exp %h", s_r_data, (i == 0) ? 8'h00 : 8'h0F + 8'(i));
            end
            tick();
            checks++;
            if (s_r_data !== 8'h10 + 8'(i) || s_count !== 4'(7 - i)) begin
                errors++; $display("FAIL drain_std: got data %h count %0d exp %h %0d", s_r_data, s_count, 8'h10 + 8'(i), 7 - i);
            end
            checks++;
            if ({s_full, s_af, s_empty, s_ae} !== exp_flags(7 - i)) begin
                errors++; $display("FAIL drain_flags: got %b exp %b", {s_full, s_af, s_empty, s_ae}, exp_flags(7 - i));
            end
        end
        tick();
        r_en = 1'b0;
        checks++;
        if (s_un !== 1'b1 || f_un !== 1'b1 || s_r_data !== 8'h17 || s_count !== 4'd0) begin
            errors++; $display("FAIL drain_underflow: got un %b/%b data %h count %0d exp 1/1 17 0", s_un, f_un, s_r_data, s_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        do_clr();
        for (int k = 0; k < 4; k++) begin
            w_en = 1'b1; w_data = 8'h20 + 8'(k);
            tick();
            q.push_back(w_data);
        end
        for (int k = 0; k < 20; k++) begin
            w_en = 1'b1; r_en = 1'b1; w_data = 8'h30 + 8'(k);
            checks++;
            if (f_r_data !== q[0]) begin
                errors++; $display("FAIL b2b_fwft_head: got %h exp %h", f_r_data, q[0]);
            end
            tick();
            exp = q.pop_front();
            q.push_back(w_data);
            checks++;
            if (s_r_data !== exp || s_count !== 4'd4 || f_count !== 4'd4) begin
                errors++; $display("FAIL b2b_std: got data %h count %0d/%0d exp %h 4", s_r_data, s_count, f_count, exp);
            end
        end
        r_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_data = 8'h50 + 8'(k);
            tick();
            q.push_back(w_data);
        end
        // Full with both requests: only the read may happen.
        w_en = 1'b1; r_en = 1'b1; w_data = 8'hEE;
        tick();
        exp = q.pop_front();
        checks++;
        if (s_count !== 4'd7 || s_r_data !== exp || s_ov !== 1'b1 || s_full !== 1'b0) begin
            errors++; $display("FAIL b2b_full_both: got count %0d data %h ov %b full %b exp 7 %h 1 0", s_count, s_r_data, s_ov, s_full, exp);
        end
        w_en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            exp = q.pop_front();
            checks++;
            if (s_r_data !== exp) begin
                errors++; $display("FAIL b2b_drain: got %h exp %h", s_r_data, exp);
            end
        end
        // Empty with both requests: only the write may happen.
        w_en = 1'b1; r_en = 1'b1; w_data = 8'h77;
        tick();
        w_en = 1'b0; r_en = 1'b0;
        checks++;
        if (s_count !== 4'd1 || s_un !== 1'b1 || s_empty !== 1'b0 || f_r_data !== 8'h77 || s_r_data !== exp) begin
            errors++; $display("FAIL b2b_empty_both: got count %0d un %b empty %b fwft %h std %h exp 1 1 0 77 %h", s_count, s_un, s_empty, f_r_data, s_r_data, exp);
        end
    endtask

    task automatic test_fwft();
        do_clr();
        w_en = 1'b1; w_data = 8'hA5;
        tick();
        w_en = 1'b0;
        checks++;
        if (f_r_data !== 8'hA5 || f_empty !== 1'b0) begin
            errors++; $display("FAIL fwft_first_word: got %h empty %b exp a5 0", f_r_data, f_empty);
        end
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        checks++;
        if (f_empty !== 1'b1 || s_r_data !== 8'hA5) begin
            errors++; $display("FAIL fwft_pop: got empty %b std %h exp 1 a5", f_empty, s_r_data);
        end
    endtask

    task automatic test_clr();
        do_clr();
        w_en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            w_data = 8'h60 + 8'(k);
            tick();
        end
        w_en = 1'b0; r_en = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        r_en = 1'b0;
        checks++;
        if (s_count !== 4'd5 || s_ov !== 1'b1) begin
            errors++; $display("FAIL clr_setup: got count %0d ov %b exp 5 1", s_count, s_ov);
        end
        clr = 1'b1; w_en = 1'b1; r_en = 1'b1; w_data = 8'hFF;
        tick();
        clr = 1'b0; w_en = 1'b0; r_en = 1'b0;
        checks++;
        if (s_count !== 4'd0 || {s_full, s_af, s_empty, s_ae, s_ov, s_un} !== 6'b001100) begin
            errors++; $display("FAIL clr_state: got count %0d flags %b exp 0 001100", s_count, {s_full, s_af, s_empty, s_ae, s_ov, s_un});
        end
        w_en = 1'b1; w_data = 8'h3C;
        tick();
        w_en = 1'b0;
        checks++;
        if (f_r_data !== 8'h3C) begin
            errors++; $display("FAIL clr_fwft_reuse: got %h exp 3c", f_r_data);
        end
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
        checks++;
        if (s_r_data !== 8'h3C || s_count !== 4'd0) begin
            errors++; $display("FAIL clr_std_reuse: got %h count %0d exp 3c 0", s_r_data, s_count);
        end
    endtask

    task automatic test_reset_mid();
        do_clr();
        w_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w_data = 8'h40 + 8'(k);
            tick();
        end
        w_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (s_count !== 4'd0 || s_empty !== 1'b1 || s_ae !== 1'b1 || s_r_data !== 8'h00 || f_count !== 4'd0) begin
            errors++; $display("FAIL reset_async: got count %0d empty %b ae %b data %h exp 0 1 1 00", s_count, s_empty, s_ae, s_r_data);
        end
        tick();
        rst_n = 1'b1;
        w_en = 1'b1; w_data = 8'h55;
        tick();
        w_en = 1'b0; r_en = 1'b1;
        checks++;
        if (s_count !== 4'd1 || f_r_data !== 8'h55) begin
            errors++; $display("FAIL reset_first_write: got count %0d fwft %h exp 1 55", s_count, f_r_data);
        end
        tick();
        r_en = 1'b0;
        checks++;
        if (s_r_data !== 8'h55 || s_empty !== 1'b1) begin
            errors++; $display("FAIL reset_discard: got %h empty %b exp 55 1", s_r_data, s_empty);
        end
    endtask

    task automatic test_random();
        logic wf, rf;
        logic [7:0] exp;
        do_clr();
        for (int n = 0; n < 2000; n++) begin
            w_en   = ($urandom_range(0, 99) < 60);
            r_en   = ($urandom_range(0, 99) < 60);
            w_data = 8'($urandom_range(0, 255));
            wf = w_en && (q.size() < 8);
            rf = r_en && (q.size() > 0);
            if (q.size() > 0) begin
                checks++;
                if (f_r_data !== q[0]) begin
                    errors++; $display("FAIL rand_fwft_head: cycle %0d got %h exp %h", n, f_r_data, q[0]);
                end
            end
            tick();
            if (rf) begin
                exp = q.pop_front();
                checks++;
                if (s_r_data !== exp) begin
                    errors++; $display("FAIL rand_std_data: cycle %0d got %h exp %h", n, s_r_data, exp);
                end
            end
            if (wf) q.push_back(w_data);
            checks++;
            if (s_count !== 4'(q.size()) || f_count !== 4'(q.size()) ||
                {s_full, s_af, s_empty, s_ae} !== exp_flags(q.size())) begin
                errors++; $display("FAIL rand_count: cycle %0d got %0d/%0d flags %b exp %0d %b", n, s_count, f_count, {s_full, s_af, s_empty, s_ae}, q.size(), exp_flags(q.size()));
            end
        end
        w_en = 1'b0; r_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_std();
        test_back_to_back();
        test_fwft();
        test_clr();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
